// File: rtl/fp_dot_seq.sv
// Sequential signed fixed-point dot product: one pair per transfer, saturating accumulate.
// Done pulses one cycle after the final transfer; in_valid stalls hold state indefinitely.

module fp_mult #(
    parameter int n = 8,
    parameter int f = 7
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] p
);
    localparam logic signed [2*n:0] RND  = {{(2*n){1'b0}}, 1'b1} << (f - 1);
    localparam logic signed [2*n:0] MAXV = {{(n+2){1'b0}}, {(n-1){1'b1}}};
    localparam logic signed [2*n:0] MINV = {{(n+2){1'b1}}, {(n-1){1'b0}}};

    logic signed [2*n-1:0] full;
    logic signed [2*n:0]   rnd;
    logic signed [2*n:0]   shr;

    always_comb begin
        full = $signed({{n{a[n-1]}}, a}) * $signed({{n{b[n-1]}}, b});
        // Round half toward +inf, then clamp (only -1 * -1 can exceed range).
        rnd  = $signed({full[2*n-1], full}) + RND;
        shr  = rnd >>> f;
        if (shr > MAXV)
            p = MAXV[n-1:0];
        else if (shr < MINV)
            p = MINV[n-1:0];
        else
            p = shr[n-1:0];
    end
endmodule

module fp_dot_seq #(
    parameter int n  = 8,
    parameter int f  = 7,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic [n-1:0]  a_in,
    input  logic [n-1:0]  b_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [n-1:0]  result,
    output logic          ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] cnt;
    logic [n-1:0]  acc;
    logic [n-1:0]  prod;
    logic [n:0]    sum;
    logic          clamp;
    logic [n-1:0]  sat;
    logic          xfer;

    fp_mult #(.n(n), .f(f)) u_mult (
        .a (a_in),
        .b (b_in),
        .p (prod)
    );

    always_comb begin
        sum   = {acc[n-1], acc} + {prod[n-1], prod};
        clamp = sum[n] ^ sum[n-1];
        if (clamp)
            sat = sum[n] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
        else
            sat = sum[n-1:0];
    end

    // Abort wins over a coincident transfer.
    assign xfer = (state == RUN) && in_valid && !abort;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (len != '0) ? RUN : DONE;
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort)
                    state_nxt = IDLE;
                else if (in_valid && cnt == LW'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                cnt <= len;
                acc <= '0;
                ovf <= 1'b0;
                if (len == '0)
                    result <= '0;
            end
            if (xfer) begin
                acc <= sat;
                cnt <= cnt - LW'(1);
                if (clamp)
                    ovf <= 1'b1;
                if (cnt == LW'(1))
                    result <= sat;
            end
        end
    end
endmodule
